// File: rtl/vote_tally_reader.sv
// Readout controller for the ballot counter: requests the grand total, steps
// through every candidate tally into a local table, then evaluates the result.
module vote_tally_reader #(
  parameter int unsigned NCAND      = 15,
  parameter int unsigned SAMPLE_DLY = 3,
  parameter int unsigned GAP        = 2,
  parameter int unsigned CLOSE_CYC  = 3,
  parameter int unsigned CLR_CYC    = 2
) (
  input  logic        clk,
  input  logic        Power,
  input  logic        start,
  input  logic        clr_req,
  input  logic [11:0] tally_in,
  output logic        Total,
  output logic        Close,
  output logic        Result,
  output logic        Clear,
  output logic        Ballot,
  output logic        busy,
  output logic        done,
  output logic [11:0] total,
  output logic [3:0]  winner,
  output logic [11:0] win_count,
  output logic        tie,
  output logic        mismatch,
  input  logic [3:0]  rd_idx,
  output logic [11:0] rd_data
);

  typedef enum logic [3:0] {
    IDLE, CLR, TOT_REQ, TOT_WAIT, CLOSE, RES_HI, RES_LO, EVAL, DONE
  } state_t;

  localparam int unsigned TBL_N      = 16;
  localparam logic [2:0]  SD_LAST    = 3'(SAMPLE_DLY - 1);
  localparam logic [2:0]  GAP_LAST   = 3'(GAP - 1);
  localparam logic [2:0]  CLOSE_LAST = 3'(CLOSE_CYC - 1);
  localparam logic [2:0]  CLR_LAST   = 3'(CLR_CYC - 1);
  localparam logic [3:0]  K_LAST     = 4'(NCAND);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [3:0]  k;
  logic [15:0] sum;
  logic [11:0] tbl [0:TBL_N-1];

  logic        total_nxt, close_nxt, result_nxt, clear_nxt;
  logic [3:0]  best_idx;
  logic [11:0] best_val;
  logic        tie_c;

  // State register; control strobes are registered from the next state so
  // they change on the same edge as the state they belong to.
  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      state  <= IDLE;
      cnt    <= '0;
      Total  <= 1'b0;
      Close  <= 1'b0;
      Result <= 1'b0;
      Clear  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= (state_nxt == state) ? cnt + 3'd1 : '0;
      Total  <= total_nxt;
      Close  <= close_nxt;
      Result <= result_nxt;
      Clear  <= clear_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_req)    state_nxt = CLR;
        else if (start) state_nxt = TOT_REQ;
      end
      CLR:      if (cnt == CLR_LAST)   state_nxt = IDLE;
      TOT_REQ:                         state_nxt = TOT_WAIT;
      TOT_WAIT: if (cnt == SD_LAST)    state_nxt = CLOSE;
      CLOSE:    if (cnt == CLOSE_LAST) state_nxt = RES_HI;
      RES_HI:   if (cnt == SD_LAST)    state_nxt = RES_LO;
      RES_LO:   if (cnt == GAP_LAST)   state_nxt = (k == K_LAST) ? EVAL : RES_HI;
      EVAL:                            state_nxt = DONE;
      DONE:                            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    total_nxt  = (state_nxt == TOT_REQ);
    close_nxt  = (state_nxt == CLOSE);
    result_nxt = (state_nxt == RES_HI);
    clear_nxt  = (state_nxt == CLR);
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

  // Ascending scan: strictly-greater replaces, so the lowest index keeps ties.
  always_comb begin
    best_idx = '0;
    best_val = '0;
    tie_c    = 1'b0;
    for (int unsigned i = 1; i <= NCAND; i++) begin
      if (tbl[4'(i)] > best_val) begin
        best_val = tbl[4'(i)];
        best_idx = 4'(i);
        tie_c    = 1'b0;
      end else if ((tbl[4'(i)] == best_val) && (best_val != '0)) begin
        tie_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      k         <= '0;
      sum       <= '0;
      total     <= '0;
      winner    <= '0;
      win_count <= '0;
      tie       <= 1'b0;
      mismatch  <= 1'b0;
      for (int unsigned i = 0; i < TBL_N; i++) tbl[4'(i)] <= '0;
    end else begin
      case (state)
        CLR: begin
          k         <= '0;
          sum       <= '0;
          total     <= '0;
          winner    <= '0;
          win_count <= '0;
          tie       <= 1'b0;
          mismatch  <= 1'b0;
          for (int unsigned i = 0; i < TBL_N; i++) tbl[4'(i)] <= '0;
        end
        TOT_WAIT: if (cnt == SD_LAST) total <= tally_in;
        CLOSE: begin
          k   <= 4'd1;
          sum <= '0;
        end
        RES_HI: if (cnt == SD_LAST) begin
          tbl[k] <= tally_in;
          sum    <= sum + {4'b0, tally_in};
        end
        RES_LO: if ((cnt == GAP_LAST) && (k != K_LAST)) k <= k + 4'd1;
        EVAL: begin
          winner    <= best_idx;
          win_count <= best_val;
          tie       <= tie_c;
          mismatch  <= (sum != {4'b0, total});
        end
        default: ;
      endcase
    end
  end

  assign rd_data = tbl[rd_idx];
  assign Ballot  = 1'b0;

endmodule
